// File: rtl/ppu_lcd_vout_gen.sv
// LCD scan-out: parametrised timing, power-of-two scaled 256x240 game window, double-buffer page handshake.
// Pins lag the counters by RD_LAT+1 clocks. No backpressure: a free-running raster that never stalls.
// Build option PPU_VOUT_TESTPAT_EN adds i_testpat (8 vertical colour bars in the game window).
module ppu_lcd_vout_gen #(
  parameter int H_TOTAL  = 1056,
  parameter int H_START  = 46,
  parameter int H_ACTIVE = 800,
  parameter int HSD_W    = 30,
  parameter int V_TOTAL  = 525,
  parameter int V_START  = 23,
  parameter int V_ACTIVE = 480,
  parameter int VSD_W    = 13,
  parameter int SCALE_SH = 1,
  parameter int GX0      = 0,
  parameter int GY0      = 0,
  parameter int RD_LAT   = 1
) (
  input  logic        i_lcd_clk,
  input  logic        i_lcd_rst,
  output logic [16:0] o_vbuf_addr,
  input  logic [23:0] i_vbuf_rgb,
  input  logic [23:0] i_border_rgb,
  input  logic        i_flip_x,
  input  logic        i_flip_y,
  input  logic        i_frame_done,
`ifdef PPU_VOUT_TESTPAT_EN
  input  logic        i_testpat,
`endif
  output logic        o_wr_page,
  output logic        o_frame_start,
  output logic        o_vblank,
  output logic [7:0]  o_repeat_cnt,
  output logic [7:0]  o_lcd_r,
  output logic [7:0]  o_lcd_g,
  output logic [7:0]  o_lcd_b,
  output logic        o_lcd_hsd,
  output logic        o_lcd_vsd,
  output logic        o_lcd_de
);

  localparam int XW    = $clog2(H_TOTAL);
  localparam int YW    = $clog2(V_TOTAL);
  localparam int WIN_W = 256 << SCALE_SH;
  localparam int WIN_H = 240 << SCALE_SH;

  typedef struct packed {
    logic       hsd;
    logic       vsd;
    logic       de;
    logic       win;
`ifdef PPU_VOUT_TESTPAT_EN
    logic       tp;
    logic [2:0] bar;
`endif
  } pipe_t;

  logic [XW-1:0] x;
  logic [YW-1:0] line;
  logic [31:0]   xi, li, ax, ay, vy;
  logic          x_last, frame_last;
  logic          c_de, c_win;
  logic [7:0]    gx_s, gy_s, gx, gy;
  logic          page, pending, flip_x_q, flip_y_q;
  logic [23:0]   rgb_q, win_rgb;
  pipe_t         c_stage, d;
  pipe_t         pipe [RD_LAT];

  assign xi         = 32'(x);
  assign li         = 32'(line);
  assign x_last     = (xi == H_TOTAL - 1);
  assign frame_last = x_last && (li == V_TOTAL - 1);

  always_ff @(posedge i_lcd_clk) begin
    if (i_lcd_rst) begin
      x    <= '0;
      line <= '0;
    end else if (x_last) begin
      x    <= '0;
      line <= (li == V_TOTAL - 1) ? '0 : line + 1'b1;
    end else begin
      x <= x + 1'b1;
    end
  end

  // Unsigned offsets: positions left of / above the window wrap to huge values and fail the bound.
  assign ax    = xi - 32'(H_START + GX0);
  assign ay    = li - 32'(V_START + GY0);
  assign vy    = li - 32'(V_START + GY0);
  assign c_de  = (xi >= H_START) && (xi < H_START + H_ACTIVE) &&
                 (li >= V_START) && (li < V_START + V_ACTIVE);
  assign c_win = c_de && (ax < 32'(WIN_W)) && (ay < 32'(WIN_H));

  assign gx_s        = 8'(ax >> SCALE_SH);
  assign gy_s        = 8'(ay >> SCALE_SH);
  assign gx          = flip_x_q ? 8'd255 - gx_s : gx_s;
  assign gy          = flip_y_q ? 8'd239 - gy_s : gy_s;
  assign o_vbuf_addr = {page, gy, gx};

  assign o_frame_start = (x == '0) && (line == '0) && !i_lcd_rst;
  assign o_vblank      = !(vy < 32'(WIN_H));
  assign o_wr_page     = ~page;

`ifdef PPU_VOUT_TESTPAT_EN
  logic testpat_q;
`endif

  always_ff @(posedge i_lcd_clk) begin
    if (i_lcd_rst) begin
      page         <= 1'b1;
      pending      <= 1'b0;
      o_repeat_cnt <= '0;
      flip_x_q     <= 1'b0;
      flip_y_q     <= 1'b0;
`ifdef PPU_VOUT_TESTPAT_EN
      testpat_q    <= 1'b0;
`endif
    end else begin
      if (o_frame_start) begin
        flip_x_q  <= i_flip_x;
        flip_y_q  <= i_flip_y;
`ifdef PPU_VOUT_TESTPAT_EN
        testpat_q <= i_testpat;
`endif
      end
      // A done pulse landing on the final clock still counts for this frame's swap.
      if (frame_last) begin
        if (pending || i_frame_done) begin
          page         <= ~page;
          pending      <= 1'b0;
          o_repeat_cnt <= '0;
        end else if (o_repeat_cnt != 8'hFF) begin
          o_repeat_cnt <= o_repeat_cnt + 8'd1;
        end
      end else if (i_frame_done) begin
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    c_stage     = '0;
    c_stage.hsd = (xi >= HSD_W);
    c_stage.vsd = (li >= VSD_W);
    c_stage.de  = c_de;
    c_stage.win = c_win;
`ifdef PPU_VOUT_TESTPAT_EN
    c_stage.tp  = testpat_q;
    c_stage.bar = gx_s[7:5];
`endif
  end

  always_ff @(posedge i_lcd_clk) begin
    if (i_lcd_rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= c_stage;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign d = pipe[RD_LAT-1];

`ifdef PPU_VOUT_TESTPAT_EN
  assign win_rgb = d.tp ? {{8{d.bar[0]}}, {8{d.bar[1]}}, {8{d.bar[2]}}} : i_vbuf_rgb;
`else
  assign win_rgb = i_vbuf_rgb;
`endif

  always_ff @(posedge i_lcd_clk) begin
    if (i_lcd_rst) begin
      rgb_q     <= '0;
      o_lcd_hsd <= 1'b0;
      o_lcd_vsd <= 1'b0;
      o_lcd_de  <= 1'b0;
    end else begin
      o_lcd_hsd <= d.hsd;
      o_lcd_vsd <= d.vsd;
      o_lcd_de  <= d.de;
      if (d.win)     rgb_q <= win_rgb;
      else if (d.de) rgb_q <= i_border_rgb;
      else           rgb_q <= '0;
    end
  end

  assign o_lcd_r = rgb_q[23:16];
  assign o_lcd_g = rgb_q[15:8];
  assign o_lcd_b = rgb_q[7:0];

endmodule

// File: tb/tb_ppu_lcd_vout_gen.sv
// Directed bench for ppu_lcd_vout_gen on a 20x10 raster; instance a has the window at the active origin, b offset by (8,1).
module tb_ppu_lcd_vout_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_done, flip_x, flip_y;
  logic [23:0] border_rgb;
  logic [23:0] a_vbuf_rgb, vb_d1, vb_d2;
  logic [16:0] a_addr, b_addr;
  logic        a_wr_page, a_fs, a_vblank, a_hsd, a_vsd, a_de;
  logic        b_wr_page, b_fs, b_vblank, b_hsd, b_vsd, b_de;
  logic [7:0]  a_rep, a_r, a_g, a_b, b_rep, b_r, b_g, b_b;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int de_cnt = 0;
  int hsd_low = 0;

  always #5 clk = ~clk;

  ppu_lcd_vout_gen #(
    .H_TOTAL(20), .H_START(4), .H_ACTIVE(12), .HSD_W(2),
    .V_TOTAL(10), .V_START(2), .V_ACTIVE(6), .VSD_W(1),
    .SCALE_SH(1), .GX0(0), .GY0(0), .RD_LAT(2)
  ) dut_a (
    .i_lcd_clk(clk), .i_lcd_rst(rst), .o_vbuf_addr(a_addr), .i_vbuf_rgb(a_vbuf_rgb),
    .i_border_rgb(border_rgb), .i_flip_x(flip_x), .i_flip_y(flip_y), .i_frame_done(frame_done),
`ifdef PPU_VOUT_TESTPAT_EN
    .i_testpat(1'b0),
`endif
    .o_wr_page(a_wr_page), .o_frame_start(a_fs), .o_vblank(a_vblank), .o_repeat_cnt(a_rep),
    .o_lcd_r(a_r), .o_lcd_g(a_g), .o_lcd_b(a_b), .o_lcd_hsd(a_hsd), .o_lcd_vsd(a_vsd), .o_lcd_de(a_de)
  );

  ppu_lcd_vout_gen #(
    .H_TOTAL(20), .H_START(4), .H_ACTIVE(12), .HSD_W(2),
    .V_TOTAL(10), .V_START(2), .V_ACTIVE(6), .VSD_W(1),
    .SCALE_SH(1), .GX0(8), .GY0(1), .RD_LAT(2)
  ) dut_b (
    .i_lcd_clk(clk), .i_lcd_rst(rst), .o_vbuf_addr(b_addr), .i_vbuf_rgb(24'hABCDEF),
    .i_border_rgb(border_rgb), .i_flip_x(flip_x), .i_flip_y(flip_y), .i_frame_done(frame_done),
`ifdef PPU_VOUT_TESTPAT_EN
    .i_testpat(1'b0),
`endif
    .o_wr_page(b_wr_page), .o_frame_start(b_fs), .o_vblank(b_vblank), .o_repeat_cnt(b_rep),
    .o_lcd_r(b_r), .o_lcd_g(b_g), .o_lcd_b(b_b), .o_lcd_hsd(b_hsd), .o_lcd_vsd(b_vsd), .o_lcd_de(b_de)
  );

  // Frame-buffer model: returns the address as colour, two clocks late.
  always @(posedge clk) begin
    vb_d1 <= {7'b0, a_addr};
    vb_d2 <= vb_d1;
  end
  assign a_vbuf_rgb = vb_d2;

  // cyc tracks the DUT raster position (x + 20*line + 200*frame) since the last reset edge.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  always @(negedge clk) begin
    if (cyc >= 203 && cyc < 403) begin
      de_cnt  = de_cnt + int'(a_de);
      hsd_low = hsd_low + int'(!a_hsd);
    end
  end

  typedef struct {
    int          x;
    int          ln;
    logic        hsd;
    logic        vsd;
    logic        de;
    logic [23:0] ra;
    logic [23:0] rb;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    int n;
    n = 0;
    while (cyc != target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      n_fail++;
      n_checks++;
      $display("FAIL timeout: cycle %0d, waiting for %0d", cyc, target);
    end
  endtask

  task automatic pulse_done();
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{0,  0, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000};
    vecs[1]  = '{1,  0, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000};
    vecs[2]  = '{2,  0, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h000000};
    vecs[3]  = '{0,  1, 1'b0, 1'b1, 1'b0, 24'h000000, 24'h000000};
    vecs[4]  = '{3,  2, 1'b1, 1'b1, 1'b0, 24'h000000, 24'h000000};
    vecs[5]  = '{4,  2, 1'b1, 1'b1, 1'b1, 24'h010000, 24'h123456};
    vecs[6]  = '{5,  2, 1'b1, 1'b1, 1'b1, 24'h010000, 24'h123456};
    vecs[7]  = '{6,  2, 1'b1, 1'b1, 1'b1, 24'h010001, 24'h123456};
    vecs[8]  = '{8,  2, 1'b1, 1'b1, 1'b1, 24'h010002, 24'h123456};
    vecs[9]  = '{9,  2, 1'b1, 1'b1, 1'b1, 24'h010002, 24'h123456};
    vecs[10] = '{15, 2, 1'b1, 1'b1, 1'b1, 24'h010005, 24'h123456};
    vecs[11] = '{16, 2, 1'b1, 1'b1, 1'b0, 24'h000000, 24'h000000};
    vecs[12] = '{11, 3, 1'b1, 1'b1, 1'b1, 24'h010003, 24'h123456};
    vecs[13] = '{12, 3, 1'b1, 1'b1, 1'b1, 24'h010004, 24'hABCDEF};
    vecs[14] = '{4,  4, 1'b1, 1'b1, 1'b1, 24'h010100, 24'h123456};
    vecs[15] = '{15, 7, 1'b1, 1'b1, 1'b1, 24'h010205, 24'hABCDEF};
    vecs[16] = '{4,  8, 1'b1, 1'b1, 1'b0, 24'h000000, 24'h000000};
    vecs[17] = '{19, 9, 1'b1, 1'b1, 1'b0, 24'h000000, 24'h000000};

    rst = 1'b1; frame_done = 1'b0; flip_x = 1'b0; flip_y = 1'b0; border_rgb = 24'h123456;
    repeat (3) @(negedge clk);
    check("reset_pins", 64'({a_r, a_g, a_b, a_hsd, a_vsd, a_de}), 64'd0);
    check("reset_state", 64'({a_wr_page, a_rep, a_addr[16]}), 64'({1'b0, 8'd0, 1'b1}));
    rst = 1'b0;

    // Raster and scaling vectors in frame 0: pins at cycle p+3 reflect counter position p.
    for (int i = 0; i < 18; i++) begin
      wait_cyc(vecs[i].x + 20 * vecs[i].ln + 3);
      check($sformatf("vec%0d", i),
            64'({a_hsd, a_vsd, a_de, a_r, a_g, a_b, b_r, b_g, b_b}),
            64'({vecs[i].hsd, vecs[i].vsd, vecs[i].de, vecs[i].ra, vecs[i].rb}));
    end

    // Page handshake.
    wait_cyc(250); pulse_done();
    wait_cyc(300);  check("rep_after_f0", 64'(a_rep), 64'd1);
    wait_cyc(399);  check("wrpage_before_swap", 64'(a_wr_page), 64'd0);
    wait_cyc(400);  check("swap1", 64'({a_wr_page, a_addr[16], a_rep}), 64'({1'b1, 1'b0, 8'd0}));
    wait_cyc(403);  check("line_timing", 64'({de_cnt[15:0], hsd_low[15:0]}), 64'({16'd72, 16'd20}));
    wait_cyc(1000); check("repeat3", 64'({a_wr_page, a_rep}), 64'({1'b1, 8'd3}));
    wait_cyc(1050); pulse_done();
    wait_cyc(1100); pulse_done();
    wait_cyc(1200); check("double_done_swap", 64'({a_wr_page, a_rep}), 64'({1'b0, 8'd0}));
    wait_cyc(1400); check("double_done_absorbed", 64'({a_wr_page, a_rep}), 64'({1'b0, 8'd1}));
    wait_cyc(1599); check("wrpage_pre_last", 64'(a_wr_page), 64'd0);
    pulse_done();
    check("last_clock_swap", 64'({a_wr_page, a_rep}), 64'({1'b1, 8'd0}));

    // Flips requested mid-frame take effect only from the next frame start.
    wait_cyc(1650); flip_x = 1'b1; flip_y = 1'b1;
    wait_cyc(1664); check("flip_held0", 64'(a_addr), 64'h00000);
    wait_cyc(1666); check("flip_held1", 64'(a_addr), 64'h00001);
    wait_cyc(1799); check("fs_before", 64'(a_fs), 64'd0);
    wait_cyc(1800); check("fs_pulse", 64'(a_fs), 64'd1);
    wait_cyc(1801); check("fs_after", 64'(a_fs), 64'd0);
    wait_cyc(1820); check("vblank_l1", 64'({a_vblank, b_vblank}), 64'b11);
    wait_cyc(1840); check("vblank_l2", 64'({a_vblank, b_vblank}), 64'b01);
    wait_cyc(1844); check("flip_addr0", 64'(a_addr), 64'h0EFFF);
    wait_cyc(1846); check("flip_addr1", 64'(a_addr), 64'h0EFFE);
    wait_cyc(1847); check("flip_pin", 64'({a_r, a_g, a_b}), 64'h00EFFF);
    wait_cyc(1860); check("vblank_b_l3", 64'(b_vblank), 64'd0);
    wait_cyc(1884); check("flip_addr_row2", 64'(a_addr), 64'h0EEFF);
    wait_cyc(1900); flip_x = 1'b0; flip_y = 1'b0;
    wait_cyc(2000); check("rep_before_reset", 64'(a_rep), 64'd2);

    // Mid-line reset aborts the frame and restores page 1.
    wait_cyc(2050);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_pins", 64'({a_r, a_g, a_b, a_hsd, a_vsd, a_de}), 64'd0);
    check("midreset_state", 64'({a_wr_page, a_rep, a_addr[16]}), 64'({1'b0, 8'd0, 1'b1}));
    rst = 1'b0;
    #1;
    check("fs_after_release", 64'(a_fs), 64'd1);
    @(negedge clk);
    check("fs_one_clock", 64'(a_fs), 64'd0);
    wait_cyc(44); check("post_reset_addr", 64'(a_addr), 64'h10000);
    wait_cyc(47); check("post_reset_pin", 64'({a_de, a_r, a_g, a_b}), 64'({1'b1, 24'h010000}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ppu_lcd_vout_gen.md
Name: ppu_lcd_vout_gen

Overview:
Parametrised LCD scan-out engine, successor to the fixed 800x480 LCD output stage. Generates LCD timing from parameters and scales the 256x240 PPU frame buffer by a power of two into a positionable game window. Manages double-buffer page swap through a handshake with the PPU writer, so a page is never shown half-written. Compensates a configurable frame-buffer read latency so sync, enable and colour stay aligned. Sits between the PPU frame buffer (plus external palette lookup) and the LCD pins.

Parameters:
H_TOTAL, 1056, clocks per line
H_START, 46, first active clock of a line
H_ACTIVE, 800, active clocks per line
HSD_W, 30, clocks HSD is held low at line start
V_TOTAL, 525, lines per frame
V_START, 23, first active line
V_ACTIVE, 480, active lines
VSD_W, 13, lines VSD is held low at frame start
SCALE_SH, 1, game pixel is (1<<SCALE_SH) LCD pixels square
GX0, 0, game window x offset within active area
GY0, 0, game window y offset within active area
RD_LAT, 1, vbuf read latency in clocks (1..4)

Ports:
i_lcd_clk  in  1  pixel clock
i_lcd_rst  in  1  synchronous reset, active high
o_vbuf_addr  out  17  {page, gy[7:0], gx[7:0]}, combinational from the counters
i_vbuf_rgb  in  24  {r,g,b}, valid RD_LAT clocks after address
i_border_rgb  in  24  colour outside the game window (active area)
i_flip_x  in  1  mirror game window horizontally
i_flip_y  in  1  mirror game window vertically
i_frame_done  in  1  one-clock pulse: PPU finished writing back page
o_wr_page  out  1  page the PPU must write (= ~display page)
o_frame_start  out  1  one-clock pulse at x=0, line=0 (counter domain)
o_vblank  out  1  counter line outside game window rows
o_repeat_cnt  out  8  saturating count of frames shown without a swap
o_lcd_r/o_lcd_g/o_lcd_b  out  8 each  pixel colour
o_lcd_hsd  out  1  horizontal sync/data enable
o_lcd_vsd  out  1  vertical sync/data enable
o_lcd_de  out  1  active-area enable

Behaviour:
- Reset (i_lcd_rst high at a clock edge): x=0, line=0, display page=1, o_wr_page=0, pending=0, o_repeat_cnt=0; all LCD outputs 0; delay pipe cleared to 0; flip latches=0.
- Counters: x 0..H_TOTAL-1 wraps; line increments on x wrap, 0..V_TOTAL-1 wraps.
- Counter-domain hsd = (x>=HSD_W); vsd = (line>=VSD_W); de = x in [H_START,H_START+H_ACTIVE) and line in [V_START,V_START+V_ACTIVE).
- Game window: ax=x-H_START-GX0, ay=line-V_START-GY0. Inside when de and 0<=ax<(256<<SCALE_SH) and 0<=ay<(240<<SCALE_SH).
- gx=ax>>SCALE_SH, gy=ay>>SCALE_SH. flip_x gives 255-gx; flip_y gives 239-gy. Outside the window the address is don't-care but driven from the unclamped truncation.
- i_flip_x/i_flip_y sampled only on the o_frame_start cycle; no mid-frame tearing.
- Alignment: hsd, vsd, de and the in-window flag pass through RD_LAT shift stages plus one output register. The colour register loads i_vbuf_rgb when the delayed in-window flag is set, i_border_rgb when only delayed de is set, else 0. Output latency from counter state to pins is RD_LAT+1 clocks.
- Page handshake: i_frame_done sets pending. On the last clock of a frame (x=H_TOTAL-1, line=V_TOTAL-1):
  - pending set: page toggles, pending clears, o_repeat_cnt clears.
  - pending clear: page holds, o_repeat_cnt increments, saturating at 255.
- i_frame_done on that exact last clock counts as pending, so the swap happens.
- A second i_frame_done before a swap is absorbed.
- o_wr_page and the address page bit change only at the swap edge.
- o_vblank = !(line in [V_START+GY0, V_START+GY0+(240<<SCALE_SH))), registered-free, counter domain.
- Reset mid-frame aborts the frame; the first post-reset frame shows page 1.

Optional Feature:
PPU_VOUT_TESTPAT_EN. When defined, adds port i_testpat (in, 1), sampled at frame start. When set, the game window shows 8 vertical colour bars of width (32<<SCALE_SH). Bar k: r=k[0]?FF:00, g=k[1]?FF:00, b=k[2]?FF:00. Latency is unchanged and vbuf data is ignored. When not defined, the port and logic are absent and the window always shows i_vbuf_rgb.

Test Plan:
- Reset: assert i_lcd_rst 3 clocks mid-line -> all LCD outputs 0, o_wr_page=0, o_repeat_cnt=0, addr[16]=1. First o_frame_start pulse follows reset release by exactly 1 clock.
- Timing, small params (H_TOTAL=20, H_START=4, H_ACTIVE=12, HSD_W=2, V_TOTAL=10, V_START=2, V_ACTIVE=6, VSD_W=1, RD_LAT=2) -> o_lcd_hsd low 2 clocks per line; o_lcd_de high 12 clocks on 6 lines; pins lag counters by 3 clocks.
- Scaling, SCALE_SH=1, GX0=0: consecutive window clocks -> gx sequence 0,0,1,1,2,2. Model returns rgb=addr -> o_lcd colours match the address issued 3 clocks earlier.
- Page swap: frame_done in frame 0 -> page 1 to 0 at the frame end. No frame_done for 3 frames -> o_repeat_cnt=3, page held. frame_done on the last clock -> swaps that frame.
- Flip: set i_flip_x mid-frame -> no change until the next frame start. Then gx=255 at window column 0; flip_y gives gy=239 on the first window row.
- Border: i_border_rgb=123456 with GX0=8 -> the first 8 active clocks output 12/34/56, and 0 outside de.
